branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side prediction block that speculatively supplies the taken/target decision, which the execute stage later confirms or rolls back.
- Direct-mapped BHT of 2-bit saturating counters plus a direct-mapped tagged BTB holding target and branch kind. Looked up combinationally with the IF PC.
- Trained one cycle after execute-stage resolution via a registered update port.
- Keeps saturating statistics counters for resolved control transfers and mispredicts.

Parameters:
- BHT_IDX_W, 6, log2 of BHT entries (64).
- BTB_IDX_W, 4, log2 of BTB entries (16).
- TAG_W, 10, BTB tag width taken from PC bits above the BTB index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  pipeline stall; while high, the update port is ignored.
- pc_if_i  in  32  fetch PC to predict.
- pred_taken_o  out  1  predict redirect for pc_if_i (combinational).
- pred_target_o  out  32  predicted target (combinational; 0 when no BTB hit).
- pred_kind_o  out  2  BTB kind on hit: 0 none, 1 B-type, 2 jal, 3 jalr.
- upd_valid_i  in  1  a control transfer resolved in EX this cycle.
- upd_pc_i  in  32  PC of the resolved instruction.
- upd_kind_i  in  2  kind of the resolved instruction, same encoding as pred_kind_o.
- upd_taken_i  in  1  actual outcome; must be 1 for jal/jalr.
- upd_target_i  in  32  actual target; bit 0 already cleared for jalr.
- upd_mispredict_i  in  1  EX flushed for this instruction.
- stat_branches_o  out  32  accepted updates.
- stat_mispredicts_o  out  32  accepted updates with mispredict set.

Behaviour:
- Index and tag fields:
  - bht_idx = pc[BHT_IDX_W+1:2].
  - btb_idx = pc[BTB_IDX_W+1:2].
  - tag = pc[TAG_W+BTB_IDX_W+1:BTB_IDX_W+2].
- Lookup is purely combinational from register arrays, with no added latency.
  - hit = valid[btb_idx] && tag match.
  - pred_kind_o = hit ? kind : 0.
  - pred_target_o = hit ? target : 0.
  - pred_taken_o = hit && (kind==jal || kind==jalr || (kind==B && bht[bht_idx][1])).
- Update stage:
  - accept = upd_valid_i && !stall && upd_kind_i!=0.
  - The update inputs are registered. The write to the arrays happens at the clock edge after the accept cycle, so the total training latency is 2 edges.
  - Back-to-back accepts are supported at one per cycle.
  - A stall during the registered cycle does not cancel the pending write.
- BHT write, B-type only:
  - Taken increments the counter, saturating at 2'b11.
  - Not taken decrements the counter, saturating at 2'b00.
  - jal/jalr never modify the BHT.
- BTB write:
  - Allocate/overwrite entry btb_idx when kind is jal or jalr, or kind is B and taken.
  - Fields written: valid=1, tag, kind, target.
  - A not-taken B-type leaves the BTB unchanged.
  - On a tag conflict, the newest entry overwrites the old one.
- Same-cycle read and write to the same entry: lookup returns the pre-write contents. There is no bypass.
- Statistics:
  - On each write-stage cycle, stat_branches_o increments.
  - stat_mispredicts_o increments if the registered mispredict is set.
  - Both counters saturate at 32'hFFFFFFFF.
- Reset (synchronous; takes effect on any edge with rst_n=0, including mid-update):
  - All BTB valid bits are cleared.
  - All BHT counters are set to 2'b01 (weakly not-taken).
  - The pending update is dropped.
  - Both statistics counters are cleared.
  - Resulting outputs: pred_taken_o=0, pred_target_o=0, pred_kind_o=0, both stats=0.
- upd_kind_i==0 with upd_valid_i=1 is ignored; it is not counted.

Decomposition:
- Shared package (define.v style):
  - kind encodings KIND_NONE/B/JAL/JALR.
  - counter constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
  - BHT reset value = CTR_WNT.
- One natural sub-module: sat_counter2. It takes the current 2-bit value and taken, and returns the next 2-bit value. It is instantiated per write path.
- BTB and BHT arrays stay in the top module.

Test Plan:
- Reset: assert rst_n=0 for 1 cycle, then lookup pc=0x100 -> pred_taken_o=0, pred_kind_o=0, target=0, stats=0.
- B-type training: update pc=0x100 kind=B taken=1 target=0x80 twice.
  - Lookup 0x100 two edges after the first accept -> kind=1, target=0x80, taken=1 (counter 10).
  - After a further 3 not-taken updates -> counter 00, taken=0, BTB still hits.
- Saturation and aliasing:
  - 5 taken updates at 0x100 -> counter stays 11.
  - Lookup 0x100+(1<<(BTB_IDX_W+2)) (same index, different tag) -> no hit, taken=0.
- jalr: update pc=0x200 kind=jalr target=0x3FC, mispredict=1 -> lookup 0x200 taken=1, target=0x3FC, stat_mispredicts_o=1, stat_branches_o=1.
- Stall: hold stall=1 with upd_valid_i=1 for 3 cycles -> no array change, stats unchanged. Deassert stall -> exactly one update counted.
- Same-cycle hazard and reset mid-op:
  - Write-stage update to 0x100 while lookup of 0x100 -> old prediction that cycle, new one next cycle.
  - rst_n=0 on the write-stage cycle -> entry remains invalid, stats=0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the fetch-side branch predictor: branch kinds, 2-bit
// counter states and the registered update record.
package branch_predictor_pkg;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_B    = 2'd1;
  localparam logic [1:0] KIND_JAL  = 2'd2;
  localparam logic [1:0] KIND_JALR = 2'd3;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [1:0] BHT_RST_VAL = CTR_WNT;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  kind;
    logic        taken;
    logic [31:0] target;
    logic        mispredict;
  } upd_t;

  function automatic logic is_jump(input logic [1:0] kind);
    return (kind == KIND_JAL) || (kind == KIND_JALR);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter step: moves one state toward the outcome.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + tagged BTB predictor with combinational lookup and a
// one-cycle registered training port; also counts resolved transfers.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BHT_IDX_W = 6,
  parameter int BTB_IDX_W = 4,
  parameter int TAG_W     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] pc_if_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  output logic [1:0]  pred_kind_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic [1:0]  upd_kind_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_mispredict_i,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispredicts_o
);

  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_LO = BTB_IDX_W + 2;
  localparam int TAG_HI = TAG_W + BTB_IDX_W + 1;

  logic [1:0]       bht_q       [BHT_N];
  logic [1:0]       bht_d       [BHT_N];
  logic             btb_valid_q [BTB_N];
  logic             btb_valid_d [BTB_N];
  logic [TAG_W-1:0] btb_tag_q   [BTB_N];
  logic [TAG_W-1:0] btb_tag_d   [BTB_N];
  logic [1:0]       btb_kind_q  [BTB_N];
  logic [1:0]       btb_kind_d  [BTB_N];
  logic [31:0]      btb_target_q[BTB_N];
  logic [31:0]      btb_target_d[BTB_N];

  upd_t        upd_q, upd_d;
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  logic [BHT_IDX_W-1:0] lk_bht_idx, wr_bht_idx;
  logic [BTB_IDX_W-1:0] lk_btb_idx, wr_btb_idx;
  logic [TAG_W-1:0]     lk_tag;
  logic                 lk_hit;
  logic [1:0]           bht_next;

  assign lk_bht_idx = pc_if_i[BHT_IDX_W+1:2];
  assign lk_btb_idx = pc_if_i[BTB_IDX_W+1:2];
  assign lk_tag     = pc_if_i[TAG_HI:TAG_LO];
  assign lk_hit     = btb_valid_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);

  // Lookup reads the registered arrays only, so a same-cycle write is not seen.
  always_comb begin
    pred_kind_o   = lk_hit ? btb_kind_q[lk_btb_idx] : KIND_NONE;
    pred_target_o = lk_hit ? btb_target_q[lk_btb_idx] : 32'd0;
    pred_taken_o  = lk_hit && (is_jump(btb_kind_q[lk_btb_idx]) ||
                    (btb_kind_q[lk_btb_idx] == KIND_B && bht_q[lk_bht_idx][1]));
  end

  always_comb begin
    upd_d.valid      = upd_valid_i && !stall && (upd_kind_i != KIND_NONE);
    upd_d.pc         = upd_pc_i;
    upd_d.kind       = upd_kind_i;
    upd_d.taken      = upd_taken_i;
    upd_d.target     = upd_target_i;
    upd_d.mispredict = upd_mispredict_i;
  end

  assign wr_bht_idx = upd_q.pc[BHT_IDX_W+1:2];
  assign wr_btb_idx = upd_q.pc[BTB_IDX_W+1:2];

  sat_counter2 u_bht_ctr (
    .ctr_i   (bht_q[wr_bht_idx]),
    .taken_i (upd_q.taken),
    .ctr_o   (bht_next)
  );

  // NOTE: every _d starts as its _q so no path leaves a signal unassigned (no latches).
  always_comb begin
    bht_d        = bht_q;
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_kind_d   = btb_kind_q;
    btb_target_d = btb_target_q;
    stat_br_d    = stat_br_q;
    stat_mp_d    = stat_mp_q;
    if (upd_q.valid) begin
      if (upd_q.kind == KIND_B) bht_d[wr_bht_idx] = bht_next;
      if (is_jump(upd_q.kind) || (upd_q.kind == KIND_B && upd_q.taken)) begin
        btb_valid_d[wr_btb_idx]  = 1'b1;
        btb_tag_d[wr_btb_idx]    = upd_q.pc[TAG_HI:TAG_LO];
        btb_kind_d[wr_btb_idx]   = upd_q.kind;
        btb_target_d[wr_btb_idx] = upd_q.target;
      end
      if (stat_br_q != 32'hFFFF_FFFF) stat_br_d = stat_br_q + 32'd1;
      if (upd_q.mispredict && stat_mp_q != 32'hFFFF_FFFF) stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_q     <= '0;
      stat_br_q <= '0;
      stat_mp_q <= '0;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= BHT_RST_VAL;
      for (int i = 0; i < BTB_N; i++) btb_valid_q[i] <= 1'b0;
    end else begin
      upd_q       <= upd_d;
      stat_br_q   <= stat_br_d;
      stat_mp_q   <= stat_mp_d;
      bht_q       <= bht_d;
      btb_valid_q <= btb_valid_d;
    end
  end

  // NOTE: BTB payload is never reset; the cleared valid bits hide stale contents.
  always_ff @(posedge clk) begin
    btb_tag_q    <= btb_tag_d;
    btb_kind_q   <= btb_kind_d;
    btb_target_q <= btb_target_d;
  end

  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mp_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_if_i[31:TAG_HI+1], pc_if_i[1:0],
                            upd_q.pc[31:TAG_HI+1], upd_q.pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a table-level model.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc_if = 32'd0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pred_kind;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'd0;
  logic [1:0]  upd_kind = 2'd0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'd0;
  logic        upd_misp = 1'b0;
  logic [31:0] stat_br, stat_mp;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall              (stall),
    .pc_if_i            (pc_if),
    .pred_taken_o       (pred_taken),
    .pred_target_o      (pred_target),
    .pred_kind_o        (pred_kind),
    .upd_valid_i        (upd_valid),
    .upd_pc_i           (upd_pc),
    .upd_kind_i         (upd_kind),
    .upd_taken_i        (upd_taken),
    .upd_target_i       (upd_target),
    .upd_mispredict_i   (upd_misp),
    .stat_branches_o    (stat_br),
    .stat_mispredicts_o (stat_mp)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tables indexed by plain PC arithmetic; trained updates wait in a queue one edge.
  typedef struct {
    logic [31:0] pc;
    int          kind;
    bit          taken;
    logic [31:0] target;
    bit          misp;
  } upd_rec_t;

  int          m_bht[64];
  bit          m_v[16];
  int          m_tag[16];
  int          m_kind[16];
  logic [31:0] m_tgt[16];
  logic [31:0] m_br, m_mp;
  upd_rec_t    pend_q[$];
  bit          model_live = 1'b0;

  function automatic int bht_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction
  function automatic int btb_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction
  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> 6) % 1024);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
      for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
      m_br = 0;
      m_mp = 0;
      pend_q.delete();
      model_live = 1'b1;
    end else begin
      if (pend_q.size() > 0) begin
        upd_rec_t u;
        int bi, ti;
        u = pend_q.pop_front();
        bi = bht_idx(u.pc);
        ti = btb_idx(u.pc);
        if (u.kind == 1) m_bht[bi] = u.taken ? ((m_bht[bi] < 3) ? m_bht[bi] + 1 : 3)
                                             : ((m_bht[bi] > 0) ? m_bht[bi] - 1 : 0);
        if (u.kind >= 2 || u.taken) begin
          m_v[ti] = 1'b1;
          m_tag[ti] = tag_of(u.pc);
          m_kind[ti] = u.kind;
          m_tgt[ti] = u.target;
        end
        if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
        if (u.misp && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
      end
      if (upd_valid && !stall && upd_kind != 2'd0) begin
        upd_rec_t n;
        n.pc = upd_pc; n.kind = int'(upd_kind); n.taken = upd_taken;
        n.target = upd_target; n.misp = upd_misp;
        pend_q.push_back(n);
      end
    end
  end

  // Compare process: outputs are combinational lookups, meaningful every cycle after reset.
  always @(negedge clk) begin
    if (model_live) begin
      int ti, bi, ek;
      bit hit, etk;
      logic [31:0] et;
      ti = btb_idx(pc_if);
      bi = bht_idx(pc_if);
      hit = m_v[ti] && (m_tag[ti] == tag_of(pc_if));
      ek = hit ? m_kind[ti] : 0;
      et = hit ? m_tgt[ti] : 32'd0;
      etk = hit && (ek >= 2 || (ek == 1 && m_bht[bi] >= 2));
      check("cyc_kind", {30'd0, pred_kind}, ek);
      check("cyc_target", pred_target, et);
      check("cyc_taken", {31'd0, pred_taken}, {31'd0, etk});
      check("cyc_stat_br", stat_br, m_br);
      check("cyc_stat_mp", stat_mp, m_mp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input bit v, input logic [31:0] pc, input logic [1:0] k,
                         input bit t, input logic [31:0] tg, input bit mp);
    upd_valid = v; upd_pc = pc; upd_kind = k;
    upd_taken = t; upd_target = tg; upd_misp = mp;
  endtask

  task automatic lit(input string nm, input logic [31:0] k, input logic [31:0] tg, input logic [31:0] tk);
    @(negedge clk);
    check({nm, "_kind"}, {30'd0, pred_kind}, k);
    check({nm, "_target"}, pred_target, tg);
    check({nm, "_taken"}, {31'd0, pred_taken}, tk);
  endtask

  task automatic lit_stats(input string nm, input logic [31:0] br, input logic [31:0] mp);
    check({nm, "_stat_br"}, stat_br, br);
    check({nm, "_stat_mp"}, stat_mp, mp);
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pc_if = 32'h100;
    lit("reset", 0, 0, 0);
    lit_stats("reset", 0, 0);

    // Two taken B updates; first is visible two edges after its accept.
    set_upd(1, 32'h100, KIND_B, 1, 32'h80, 0);
    tick();
    tick();
    set_upd(0, 0, 0, 0, 0, 0);
    lit("btrain", 1, 32'h80, 1);
    check("model_bht_after_one", m_bht[0], 2);
    tick();

    set_upd(1, 32'h100, KIND_B, 0, 32'h80, 0);
    repeat (3) tick();
    set_upd(0, 0, 0, 0, 0, 0);
    tick();
    lit("b_not_taken", 1, 32'h80, 0);
    check("model_bht_floor", m_bht[0], 0);

    set_upd(1, 32'h100, KIND_B, 1, 32'h80, 0);
    repeat (5) tick();
    set_upd(0, 0, 0, 0, 0, 0);
    tick();
    lit("b_saturate", 1, 32'h80, 1);
    check("model_bht_ceiling", m_bht[0], 3);

    pc_if = 32'h100 + (32'd1 << 6);
    lit("alias", 0, 0, 0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_upd(1, 32'h200, KIND_JALR, 1, 32'h3FC, 1);
    tick();
    set_upd(0, 0, 0, 0, 0, 0);
    tick();
    pc_if = 32'h200;
    lit("jalr", 3, 32'h3FC, 1);
    lit_stats("jalr", 1, 1);

    stall = 1'b1;
    set_upd(1, 32'h300, KIND_JAL, 1, 32'h40, 0);
    repeat (3) tick();
    pc_if = 32'h300;
    lit("stalled", 0, 0, 0);
    lit_stats("stalled", 1, 1);
    stall = 1'b0;
    tick();
    set_upd(0, 0, 0, 0, 0, 0);
    tick();
    lit("unstalled", 2, 32'h40, 1);
    lit_stats("unstalled", 2, 1);

    // Write-stage cycle: lookup still sees the old entry at the same index.
    pc_if = 32'h100;
    set_upd(1, 32'h100, KIND_B, 1, 32'h84, 0);
    tick();
    set_upd(0, 0, 0, 0, 0, 0);
    lit("hazard_old", 0, 0, 0);
    tick();
    lit("hazard_new", 1, 32'h84, 1);

    set_upd(1, 32'h180, KIND_JAL, 1, 32'h20, 0);
    tick();
    set_upd(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pc_if = 32'h180;
    lit("rst_mid", 0, 0, 0);
    lit_stats("rst_mid", 0, 0);

    // Random traffic over a small PC pool so hits, aliases and reuse are common.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] hi_bits, p;
      logic [1:0]  k;
      hi_bits = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_0000) : 32'd0;
      p = hi_bits | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      k = 2'($urandom_range(0, 3));
      set_upd($urandom_range(0, 9) < 7, p, k,
              (k >= 2) ? 1'b1 : 1'($urandom_range(0, 1)),
              $urandom & 32'hFFFF_FFFE, 1'($urandom_range(0, 1)));
      pc_if = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
            | (($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_0000) : 32'd0);
      stall = ($urandom_range(0, 4) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    set_upd(0, 0, 0, 0, 0, 0);
    stall = 1'b0;
    rst_n = 1'b1;
    tick();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
